// File: rtl/chop_pkg.sv
// Shared widths, saturation helpers and phase-monitor states for the chop demodulator.
package chop_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int ACC_W_DEF  = 32;

  // Wide enough to hold any difference or negation of two 32-bit signed samples.
  localparam int WIDE_W = 34;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } phase_state_e;

  function automatic wide_t sat_clip(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int w);
    return sat_clip(a - b, w);
  endfunction

  function automatic wide_t sat_neg(input wide_t a, input int w);
    return sat_clip(-a, w);
  endfunction

endpackage

// File: rtl/chop_demod_if.sv
// Sample stream, configuration and result bundle between the chopper chain and the demodulator.
interface chop_demod_if #(
  parameter int DATA_W = chop_pkg::DATA_W_DEF,
  parameter int ACC_W  = chop_pkg::ACC_W_DEF
);
  logic                     demod_en;
  logic                     chop_default;
  logic                     chop_in;
  logic                     hold_in;
  logic [31:0]              change_count;
  logic [31:0]              max_count;
  logic signed [DATA_W-1:0] offset;
  logic                     adc_valid;
  logic signed [DATA_W-1:0] adc_data;
  logic                     int_clr;
  logic                     demod_valid;
  logic signed [DATA_W-1:0] demod_data;
  logic                     demod_held;
  logic signed [ACC_W-1:0]  int_data;
  logic                     phase_err;

  modport master (
    output demod_en, chop_default, chop_in, hold_in, change_count, max_count,
           offset, adc_valid, adc_data, int_clr,
    input  demod_valid, demod_data, demod_held, int_data, phase_err
  );

  modport slave (
    input  demod_en, chop_default, chop_in, hold_in, change_count, max_count,
           offset, adc_valid, adc_data, int_clr,
    output demod_valid, demod_data, demod_held, int_data, phase_err
  );
endinterface

// File: rtl/chop_phase_mon.sv
// Measures chop phase lengths between edges and flags any phase that differs from the programmed length.
module chop_phase_mon
  import chop_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        sample_valid,
  input  logic        chop,
  input  logic        chop_default,
  input  logic [31:0] change_count,
  input  logic [31:0] max_count,
  output logic        phase_err
);

  phase_state_e state_q, state_d;
  logic         prev_ok_q, prev_ok_d;
  logic         prev_chop_q, prev_chop_d;
  logic [31:0]  count_q, count_d;
  logic         err_q, err_d;
  logic         chop_edge;
  logic         away;
  logic [31:0]  expected;
  logic         len_ok;

  always_comb begin
    state_d     = state_q;
    prev_ok_d   = prev_ok_q;
    prev_chop_d = prev_chop_q;
    count_d     = count_q;
    err_d       = err_q;
    chop_edge   = prev_ok_q && (chop != prev_chop_q);
    away        = (chop != chop_default);
    expected    = away ? change_count : (max_count - change_count);
    // A return-to-default length is meaningless when max_count does not exceed change_count.
    len_ok      = (count_q == expected) && (away || (max_count > change_count));

    if (clr) begin
      state_d     = IDLE;
      prev_ok_d   = 1'b0;
      prev_chop_d = 1'b0;
      count_d     = '0;
      err_d       = 1'b0;
    end else if (sample_valid) begin
      prev_ok_d   = 1'b1;
      prev_chop_d = chop;
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (chop_edge) begin
            state_d = LOCKED;
            count_d = 32'd1;
          end
        end
        LOCKED: begin
          if (chop_edge) begin
            if (!len_ok) err_d = 1'b1;
            count_d = 32'd1;
          end else if (count_q != '1) begin
            count_d = count_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_ok_q   <= 1'b0;
      prev_chop_q <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_ok_q   <= prev_ok_d;
      prev_chop_q <= prev_chop_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign phase_err = err_q;

endmodule

// File: rtl/chop_demod.sv
// Offset removal, chop-phase sign demodulation, hold substitution and integration of ADC samples.
module chop_demod
  import chop_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input logic         clk,
  input logic         rst,
  chop_demod_if.slave bus
);

  logic                     en;
  logic                     in_fire;
  logic                     v1_q, v1_d;
  logic signed [DATA_W-1:0] d1_q, d1_d;
  logic                     chop1_q, chop1_d;
  logic                     hold1_q, hold1_d;
  logic                     dv_q, dv_d;
  logic signed [DATA_W-1:0] dd_q, dd_d;
  logic                     dh_q, dh_d;
  logic signed [DATA_W-1:0] lg_q, lg_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] neg1;
  logic signed [DATA_W-1:0] d2;

  assign en      = bus.demod_en;
  assign in_fire = bus.adc_valid & en;

  always_comb begin
    v1_d    = 1'b0;
    d1_d    = d1_q;
    chop1_d = chop1_q;
    hold1_d = hold1_q;
    dv_d    = 1'b0;
    dd_d    = dd_q;
    dh_d    = 1'b0;
    lg_d    = lg_q;
    acc_d   = acc_q;
    neg1    = DATA_W'(sat_neg(wide_t'(d1_q), DATA_W));
    d2      = (chop1_q == bus.chop_default) ? d1_q : neg1;

    if (!en) begin
      d1_d    = '0;
      chop1_d = 1'b0;
      hold1_d = 1'b0;
      dd_d    = '0;
      lg_d    = '0;
      acc_d   = '0;
    end else begin
      if (in_fire) begin
        v1_d    = 1'b1;
        d1_d    = DATA_W'(sat_sub(wide_t'(bus.adc_data), wide_t'(bus.offset), DATA_W));
        chop1_d = bus.chop_in;
        hold1_d = bus.hold_in;
      end
      if (v1_q) begin
        dv_d = 1'b1;
        dh_d = hold1_q;
        if (hold1_q) begin
          dd_d = lg_q;
        end else begin
          dd_d = d2;
          lg_d = d2;
        end
      end
      // Clear wins over a coinciding sample, which is then lost.
      if (bus.int_clr) acc_d = '0;
      else if (dv_q && !dh_q) acc_d = acc_q + ACC_W'(dd_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      d1_q    <= '0;
      chop1_q <= 1'b0;
      hold1_q <= 1'b0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
      dh_q    <= 1'b0;
      lg_q    <= '0;
      acc_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      chop1_q <= chop1_d;
      hold1_q <= hold1_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
      dh_q    <= dh_d;
      lg_q    <= lg_d;
      acc_q   <= acc_d;
    end
  end

  chop_phase_mon u_phase_mon (
    .clk          (clk),
    .rst          (rst),
    .clr          (!en),
    .sample_valid (in_fire),
    .chop         (bus.chop_in),
    .chop_default (bus.chop_default),
    .change_count (bus.change_count),
    .max_count    (bus.max_count),
    .phase_err    (bus.phase_err)
  );

  assign bus.demod_valid = dv_q;
  assign bus.demod_data  = en ? dd_q : '0;
  assign bus.demod_held  = dh_q;
  assign bus.int_data    = en ? acc_q : '0;

endmodule

// File: tb/tb_chop_demod.sv
// Directed and randomized stimulus for chop_demod, checked against a sample-level reference model.
module tb_chop_demod;

  localparam int DW = 18;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  chop_demod_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

  chop_demod #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a sample waiting for demodulation, the last emitted result, and phase bookkeeping.
  logic             p_valid, p_chop, p_hold;
  int               p_d;
  logic             o_valid, o_held;
  int               o_data;
  int               lg;
  bit signed [31:0] acc;
  logic             err;
  logic             have_prev, prev_chop, locked;
  longint           run_len;

  function automatic int clip(longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  function automatic int rnd_data();
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    return int'(t);
  endfunction

  task automatic model_clear();
    p_valid = 0; p_chop = 0; p_hold = 0; p_d = 0;
    o_valid = 0; o_held = 0; o_data = 0; lg = 0; acc = 0; err = 0;
    have_prev = 0; prev_chop = 0; locked = 0; run_len = 0;
  endtask

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    longint exp_len;
    int     v;
    if (!bus.demod_en) begin
      model_clear();
      return;
    end
    if (bus.int_clr) acc = 0;
    else if (o_valid && !o_held) acc = acc + o_data;
    if (p_valid) begin
      v = (p_chop == bus.chop_default) ? p_d : clip(-longint'(p_d));
      if (p_hold) begin
        o_data = lg; o_held = 1;
      end else begin
        o_data = v; lg = v; o_held = 0;
      end
      o_valid = 1;
    end else begin
      o_valid = 0;
    end
    p_valid = bus.adc_valid;
    if (bus.adc_valid) begin
      p_d    = clip(longint'(bus.adc_data) - longint'(bus.offset));
      p_chop = bus.chop_in;
      p_hold = bus.hold_in;
      if (have_prev && bus.chop_in != prev_chop) begin
        if (locked) begin
          if (prev_chop == bus.chop_default) exp_len = longint'(bus.change_count);
          else if (bus.max_count > bus.change_count)
            exp_len = longint'(bus.max_count) - longint'(bus.change_count);
          else exp_len = -1;
          if (run_len != exp_len) err = 1;
        end
        locked = 1; run_len = 1;
      end else begin
        run_len++;
      end
      have_prev = 1; prev_chop = bus.chop_in;
    end
  endtask

  task automatic check_outputs();
    check("demod_valid", bus.demod_valid, o_valid);
    if (o_valid) begin
      check("demod_data", bus.demod_data, o_data);
      check("demod_held", bus.demod_held, o_held);
    end
    if (!bus.demod_en) check("data_masked", bus.demod_data, 0);
    check("int_data", bus.int_data, acc);
    check("phase_err", bus.phase_err, err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(logic v, int data, logic c, logic h);
    bus.adc_valid = v;
    bus.adc_data  = DW'(data);
    bus.chop_in   = c;
    bus.hold_in   = h;
    tick();
  endtask

  task automatic idle(int n);
    bus.adc_valid = 0;
    repeat (n) tick();
  endtask

  task automatic en_pulse();
    bus.demod_en  = 0;
    bus.adc_valid = 0;
    tick();
    bus.demod_en = 1;
  endtask

  initial begin
    logic c;
    bus.demod_en = 0; bus.chop_default = 0; bus.chop_in = 0; bus.hold_in = 0;
    bus.change_count = 4; bus.max_count = 10; bus.offset = 0;
    bus.adc_valid = 0; bus.adc_data = 0; bus.int_clr = 0;
    model_clear();

    // 1: reset with random inputs
    bus.demod_en = 1'($urandom); bus.adc_valid = 1'($urandom); bus.adc_data = DW'($urandom);
    bus.chop_in = 1'($urandom); bus.hold_in = 1'($urandom); bus.int_clr = 1'($urandom);
    rst = 1;
    #1;
    check("reset_valid", bus.demod_valid, 0);
    check("reset_data", bus.demod_data, 0);
    check("reset_int", bus.int_data, 0);
    check("reset_err", bus.phase_err, 0);
    @(posedge clk);
    #1;
    rst = 0;
    bus.demod_en = 1; bus.adc_valid = 0; bus.hold_in = 0; bus.chop_in = 0; bus.int_clr = 0;
    idle(3);

    // 2: basic sign demodulation
    bus.offset = 10;
    drive(1, 110, 0, 0);
    drive(1, 110, 1, 0);
    check("t2_pos", bus.demod_data, 100);
    idle(1);
    check("t2_neg", bus.demod_data, -100);
    check("t2_int1", bus.int_data, 100);
    idle(1);
    check("t2_int2", bus.int_data, 0);

    // 3: saturation corners
    bus.offset = 0;
    drive(1, -131072, 1, 0);
    bus.offset = -5;
    drive(1, 131071, 1, 0);
    check("t3_negmin", bus.demod_data, 131071);
    idle(1);
    check("t3_subsat", bus.demod_data, -131071);
    idle(2);

    // 4: hold substitution
    en_pulse();
    bus.offset = 0;
    drive(1, 100, 0, 0);
    drive(1, 200, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, rnd_data(), 0, 1);
    check("t4_held_data", bus.demod_data, 200);
    check("t4_held_flag", bus.demod_held, 1);
    check("t4_int", bus.int_data, 300);
    idle(2);
    check("t4_int_stay", bus.int_data, 300);

    // 5: phase length monitor
    en_pulse();
    bus.change_count = 4; bus.max_count = 10; bus.offset = DW'($urandom_range(0, 50));
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 4; i++) drive(1, rnd_data(), 0, $urandom_range(0, 3) == 0);
      for (int i = 0; i < 6; i++) drive(1, rnd_data(), 1, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 4; i++) drive(1, rnd_data(), 0, 0);
    check("t5_ok", bus.phase_err, 0);
    for (int i = 0; i < 5; i++) drive(1, rnd_data(), 1, 0);
    drive(1, rnd_data(), 0, 0);
    check("t5_err", bus.phase_err, 1);
    idle(3);
    check("t5_sticky", bus.phase_err, 1);
    en_pulse();
    check("t5_cleared", bus.phase_err, 0);

    // 6: integrate, clear, mid-stream reset
    en_pulse();
    bus.offset = 0;
    for (int i = 0; i < 8; i++) drive(1, 100, 0, 0);
    idle(2);
    check("t6_int800", bus.int_data, 800);
    drive(1, 100, 0, 0);
    idle(1);
    bus.int_clr = 1;
    tick();
    bus.int_clr = 0;
    idle(2);
    check("t6_intclr", bus.int_data, 0);
    for (int i = 0; i < 3; i++) drive(1, rnd_data(), 0, 0);
    bus.adc_valid = 0;
    rst = 1;
    #1;
    model_clear();
    check("t6_rst_valid", bus.demod_valid, 0);
    check("t6_rst_int", bus.int_data, 0);
    @(posedge clk);
    #1;
    rst = 0;
    idle(3);
    drive(1, 50, 0, 0);
    check("t6_lat1", bus.demod_valid, 0);
    idle(1);
    check("t6_lat2", bus.demod_valid, 1);
    check("t6_lat2_data", bus.demod_data, 50);
    idle(2);

    // Randomized soak
    en_pulse();
    bus.chop_default = 1'($urandom);
    bus.change_count = $urandom_range(1, 6);
    bus.max_count    = $urandom_range(2, 12);
    c = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) c = ~c;
      bus.offset   = DW'($urandom);
      bus.int_clr  = ($urandom_range(0, 30) == 0);
      bus.demod_en = ($urandom_range(0, 60) != 0);
      drive($urandom_range(0, 3) != 0, rnd_data(), c, $urandom_range(0, 4) == 0);
    end
    bus.int_clr = 0; bus.demod_en = 1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
